rd_addr_dispatch: RTL and testbench

Read-address forward path of the AXI interconnect. Accepts one AR request from the master, decodes ARADDR to slave 1 or slave 2, and holds the payload in a register. It forwards the request with a full VALID/READY handshake, then holds the route-select codes that steer the R channel back to the master until the burst's RLAST handshake completes. One outstanding read at a time.

---
 rtl/rd_addr_dispatch.sv | 173 +++++++++++++++++
 tb/tb_rd_addr_dispatch.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_addr_dispatch.sv
// rd_addr_dispatch: read-address forward path. Takes one AR from the master, decodes it
// to slave 1 / slave 2, forwards it registered, then steers the R return until RLAST.
// Latency: AR accepted at T, slave ARVALID/mas_sel from T+1. Backpressure: m_ARREADY=0 while a read is outstanding.
//
// Ports:
//   ACLK, ARESET               clock, asynchronous active-high reset
//   m_AR*                      master AR channel (VALID/READY, ADDR, ID, LEN, SIZE, BURST)
//   s_AR*                      registered AR payload shared by both slaves
//   s1_/s2_ARVALID/ARREADY     per-slave AR handshake
//   rd_RVALID, rd_RLAST,
//   m_RREADY                   returned R channel as seen by the master (beat counting only)
//   mas_sel1, mas_sel2         R return mux codes: 2'b01 = this slave owns R, 2'b00 = idle
//   len_err                    one-cycle pulse, cycle after a beat whose RLAST disagrees with ARLEN
//   err_R* (RD_DECERR_EN only) locally generated DECERR response for unmapped addresses
//
// Build option: define RD_DECERR_EN to answer unmapped addresses with DECERR beats;
// otherwise unmapped addresses fall through to slave 2 as the default slave.
module rd_addr_dispatch #(
  parameter logic [31:0] S1_BASE  = 32'h0000_0000,
  parameter logic [31:0] S1_LIMIT = 32'h0000_FFFF,
  parameter logic [31:0] S2_BASE  = 32'h0001_0000,
  parameter logic [31:0] S2_LIMIT = 32'h0001_FFFF
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        m_ARVALID,
  input  logic [31:0] m_ARADDR,
  input  logic [7:0]  m_ARID,
  input  logic [7:0]  m_ARLEN,
  input  logic [2:0]  m_ARSIZE,
  input  logic [1:0]  m_ARBURST,
  output logic        m_ARREADY,
  output logic [31:0] s_ARADDR,
  output logic [7:0]  s_ARID,
  output logic [7:0]  s_ARLEN,
  output logic [2:0]  s_ARSIZE,
  output logic [1:0]  s_ARBURST,
  output logic        s1_ARVALID,
  output logic        s2_ARVALID,
  input  logic        s1_ARREADY,
  input  logic        s2_ARREADY,
  input  logic        rd_RVALID,
  input  logic        rd_RLAST,
  input  logic        m_RREADY,
  output logic [1:0]  mas_sel1,
  output logic [1:0]  mas_sel2,
`ifdef RD_DECERR_EN
  output logic        err_RVALID,
  output logic [7:0]  err_RID,
  output logic [31:0] err_RDATA,
  output logic [1:0]  err_RRESP,
  output logic        err_RLAST,
`endif
  output logic        len_err
);

`ifdef RD_DECERR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, ERR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;
`endif

  state_t     state, state_nxt;
  logic       tgt_s2;       // 0: slave 1 owns the transaction, 1: slave 2
  logic [7:0] beat_cnt;
  logic       ar_acc, beat_inc, len_err_nxt;
  logic       sel_s1, dec_s2;

  // Offset-and-span compare: one unsigned compare per region, no dependence on BASE being nonzero.
  assign sel_s1 = (m_ARADDR - S1_BASE) <= (S1_LIMIT - S1_BASE);
  // Anything outside slave 1 goes to slave 2; with DECERR enabled the unmapped case is caught first.
  assign dec_s2 = ~sel_s1;

`ifdef RD_DECERR_EN
  logic sel_s2, unmapped;
  assign sel_s2    = (m_ARADDR - S2_BASE) <= (S2_LIMIT - S2_BASE);
  assign unmapped  = ~sel_s1 & ~sel_s2;
  assign err_RID   = s_ARID;
  assign err_RDATA = '0;
  assign err_RRESP = 2'b11;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      tgt_s2    <= 1'b0;
      beat_cnt  <= '0;
      len_err   <= 1'b0;
      s_ARADDR  <= '0;
      s_ARID    <= '0;
      s_ARLEN   <= '0;
      s_ARSIZE  <= '0;
      s_ARBURST <= '0;
    end else begin
      state   <= state_nxt;
      len_err <= len_err_nxt;
      if (ar_acc) begin
        s_ARADDR  <= m_ARADDR;
        s_ARID    <= m_ARID;
        s_ARLEN   <= m_ARLEN;
        s_ARSIZE  <= m_ARSIZE;
        s_ARBURST <= m_ARBURST;
        tgt_s2    <= dec_s2;
        beat_cnt  <= '0;
      end else if (beat_inc) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    m_ARREADY   = 1'b0;
    s1_ARVALID  = 1'b0;
    s2_ARVALID  = 1'b0;
    mas_sel1    = 2'b00;
    mas_sel2    = 2'b00;
    ar_acc      = 1'b0;
    beat_inc    = 1'b0;
    len_err_nxt = 1'b0;
`ifdef RD_DECERR_EN
    err_RVALID  = 1'b0;
    err_RLAST   = 1'b0;
`endif
    case (state)
      IDLE: begin
        m_ARREADY = 1'b1;
        if (m_ARVALID) begin
          ar_acc    = 1'b1;
`ifdef RD_DECERR_EN
          state_nxt = unmapped ? ERR : ADDR;
`else
          state_nxt = ADDR;
`endif
        end
      end
      ADDR: begin
        // R beats seen here belong to nobody we forwarded to, so they are not counted.
        if (tgt_s2) begin
          s2_ARVALID = 1'b1;
          mas_sel2   = 2'b01;
          if (s2_ARREADY) state_nxt = DATA;
        end else begin
          s1_ARVALID = 1'b1;
          mas_sel1   = 2'b01;
          if (s1_ARREADY) state_nxt = DATA;
        end
      end
      DATA: begin
        if (tgt_s2) mas_sel2 = 2'b01;
        else        mas_sel1 = 2'b01;
        if (rd_RVALID && m_RREADY) begin
          beat_inc = 1'b1;
          // beat_cnt is the index of this beat; only index ARLEN may carry RLAST.
          len_err_nxt = rd_RLAST ? (beat_cnt != s_ARLEN) : (beat_cnt == s_ARLEN);
          if (rd_RLAST) state_nxt = IDLE;
        end
      end
`ifdef RD_DECERR_EN
      ERR: begin
        err_RVALID = 1'b1;
        err_RLAST  = (beat_cnt == s_ARLEN);
        if (m_RREADY) begin
          beat_inc = 1'b1;
          if (beat_cnt == s_ARLEN) state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rd_addr_dispatch.sv
module tb_rd_addr_dispatch;
  localparam logic [31:0] S1_BASE  = 32'h0000_0000;
  localparam logic [31:0] S1_LIMIT = 32'h0000_FFFF;
  localparam logic [31:0] S2_BASE  = 32'h0001_0000;
  localparam logic [31:0] S2_LIMIT = 32'h0001_FFFF;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        m_ARVALID;
  logic [31:0] m_ARADDR;
  logic [7:0]  m_ARID, m_ARLEN;
  logic [2:0]  m_ARSIZE;
  logic [1:0]  m_ARBURST;
  logic        m_ARREADY;
  logic [31:0] s_ARADDR;
  logic [7:0]  s_ARID, s_ARLEN;
  logic [2:0]  s_ARSIZE;
  logic [1:0]  s_ARBURST;
  logic        s1_ARVALID, s2_ARVALID, s1_ARREADY, s2_ARREADY;
  logic        rd_RVALID, rd_RLAST, m_RREADY;
  logic [1:0]  mas_sel1, mas_sel2;
  logic        len_err;
`ifdef RD_DECERR_EN
  logic        err_RVALID, err_RLAST;
  logic [7:0]  err_RID;
  logic [31:0] err_RDATA;
  logic [1:0]  err_RRESP;
`endif

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  rd_addr_dispatch #(.S1_BASE(S1_BASE), .S1_LIMIT(S1_LIMIT), .S2_BASE(S2_BASE), .S2_LIMIT(S2_LIMIT)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m_ARVALID(m_ARVALID), .m_ARADDR(m_ARADDR), .m_ARID(m_ARID), .m_ARLEN(m_ARLEN),
    .m_ARSIZE(m_ARSIZE), .m_ARBURST(m_ARBURST), .m_ARREADY(m_ARREADY),
    .s_ARADDR(s_ARADDR), .s_ARID(s_ARID), .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE), .s_ARBURST(s_ARBURST),
    .s1_ARVALID(s1_ARVALID), .s2_ARVALID(s2_ARVALID), .s1_ARREADY(s1_ARREADY), .s2_ARREADY(s2_ARREADY),
    .rd_RVALID(rd_RVALID), .rd_RLAST(rd_RLAST), .m_RREADY(m_RREADY),
    .mas_sel1(mas_sel1), .mas_sel2(mas_sel2),
`ifdef RD_DECERR_EN
    .err_RVALID(err_RVALID), .err_RID(err_RID), .err_RDATA(err_RDATA),
    .err_RRESP(err_RRESP), .err_RLAST(err_RLAST),
`endif
    .len_err(len_err)
  );

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Reference address map: 1 = slave 1, 2 = slave 2, 0 = unmapped (DECERR build only).
  function automatic int model_route(logic [31:0] a);
    longint x;
    x = longint'(a);
    if (x >= longint'(S1_BASE) && x <= longint'(S1_LIMIT)) return 1;
    if (x >= longint'(S2_BASE) && x <= longint'(S2_LIMIT)) return 2;
`ifdef RD_DECERR_EN
    return 0;
`else
    return 2;
`endif
  endfunction

  // A burst of ARLEN+1 beats must carry RLAST exactly on beat ARLEN; any other placement is an error.
  function automatic logic model_len_err(int beat_idx, int arlen, logic last);
    if (last)  return beat_idx != arlen;
    return beat_idx == arlen;
  endfunction

  function automatic logic [7:0] obs();
    return {m_ARREADY, s1_ARVALID, s2_ARVALID, mas_sel1, mas_sel2, len_err};
  endfunction

  function automatic logic [7:0] expv(logic rdy, int av_to, int sel_to, logic le);
    logic [1:0] m1, m2;
    m1 = (sel_to == 1) ? 2'b01 : 2'b00;
    m2 = (sel_to == 2) ? 2'b01 : 2'b00;
    return {rdy, av_to == 1, av_to == 2, m1, m2, le};
  endfunction

  task automatic idle_inputs();
    m_ARVALID = 0; m_ARADDR = '0; m_ARID = '0; m_ARLEN = '0; m_ARSIZE = '0; m_ARBURST = '0;
    s1_ARREADY = 0; s2_ARREADY = 0; rd_RVALID = 0; rd_RLAST = 0; m_RREADY = 0;
  endtask

  // One full mapped read: AR accept, address phase with rdy_delay wait cycles, then last_at+1
  // R beats with RLAST on beat last_at. busy_ar keeps a different AR pending the whole time.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic [7:0] id,
                         input logic [7:0] len, input int rdy_delay, input int last_at,
                         input logic busy_ar);
    int tgt;
    logic [2:0] sz;
    logic [1:0] bu;
    logic [7:0] e;
    logic le;
    logic last;
    tgt = model_route(addr);
    sz = 3'($urandom_range(0, 7));
    bu = 2'($urandom_range(0, 3));
    m_ARVALID = 1; m_ARADDR = addr; m_ARID = id; m_ARLEN = len; m_ARSIZE = sz; m_ARBURST = bu;
    total++;
    if (m_ARREADY !== 1'b1) begin
      bad++; $display("FAIL %s ar_ready_idle: got %b want 1", tag, m_ARREADY);
    end
    step();
    m_ARVALID = busy_ar;
    m_ARADDR = ~addr; m_ARID = ~id; m_ARLEN = ~len;
    total++;
    if ({s_ARADDR, s_ARID, s_ARLEN, s_ARSIZE, s_ARBURST} !== {addr, id, len, sz, bu}) begin
      bad++; $display("FAIL %s payload_capture: got %h/%h/%h want %h/%h/%h", tag, s_ARADDR, s_ARID, s_ARLEN, addr, id, len);
    end
    for (int d = 0; d <= rdy_delay; d++) begin
      e = expv(0, tgt, tgt, 0);
      total++;
      if (obs() !== e) begin
        bad++; $display("FAIL %s addr_phase[%0d]: got %b want %b", tag, d, obs(), e);
      end
      if (tgt == 1) begin s1_ARREADY = (d == rdy_delay); s2_ARREADY = 1'($urandom); end
      else          begin s2_ARREADY = (d == rdy_delay); s1_ARREADY = 1'($urandom); end
      rd_RVALID = 1'($urandom); m_RREADY = 1'($urandom); rd_RLAST = 1'($urandom);
      step();
    end
    s1_ARREADY = 0; s2_ARREADY = 0;
    e = expv(0, 0, tgt, 0);
    total++;
    if (obs() !== e || s_ARADDR !== addr) begin
      bad++; $display("FAIL %s data_entry: got %b addr %h want %b addr %h", tag, obs(), s_ARADDR, e, addr);
    end
    for (int i = 0; i <= last_at; i++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        rd_RVALID = 1'($urandom); m_RREADY = ~rd_RVALID; rd_RLAST = 1'($urandom);
        step();
        e = expv(0, 0, tgt, 0);
        total++;
        if (obs() !== e) begin
          bad++; $display("FAIL %s beat%0d_gap: got %b want %b", tag, i, obs(), e);
        end
      end
      last = (i == last_at);
      rd_RVALID = 1; m_RREADY = 1; rd_RLAST = last;
      step();
      le = model_len_err(i, int'(len), last);
      e = last ? expv(1, 0, 0, le) : expv(0, 0, tgt, le);
      total++;
      if (obs() !== e) begin
        bad++; $display("FAIL %s beat%0d: got %b want %b", tag, i, obs(), e);
      end
    end
    m_ARVALID = 0; rd_RVALID = 0; m_RREADY = 0; rd_RLAST = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESET = 1;
    #3;
    total++;
    if (obs() !== expv(1, 0, 0, 0) || {s_ARADDR, s_ARID, s_ARLEN, s_ARSIZE, s_ARBURST} !== 53'd0) begin
      bad++; $display("FAIL reset_state: got %b payload %h want %b payload 0", obs(), s_ARADDR, expv(1, 0, 0, 0));
    end
    step(); step();
    ARESET = 0;
    step();
  endtask

  task automatic test_s1_burst();
    run_txn("s1_burst", 32'h0000_0100, 8'h11, 8'd3, 0, 3, 1'b0);
  endtask

  task automatic test_s2_wait();
    run_txn("s2_wait", 32'h0001_0040, 8'h22, 8'd1, 5, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_a", 32'h0000_8000, 8'h33, 8'd0, 0, 0, 1'b1);
    run_txn("b2b_b", 32'h0001_FFFF, 8'h34, 8'd2, 0, 2, 1'b1);
    run_txn("b2b_c", 32'h0000_FFFF, 8'h35, 8'd0, 0, 0, 1'b0);
  endtask

  task automatic test_len_err();
    run_txn("len_early", 32'h0000_0200, 8'h44, 8'd1, 0, 0, 1'b0);
    step();
    total++;
    if (obs() !== expv(1, 0, 0, 0)) begin
      bad++; $display("FAIL len_err_one_cycle: got %b want %b", obs(), expv(1, 0, 0, 0));
    end
    run_txn("len_late", 32'h0001_0004, 8'h45, 8'd0, 1, 2, 1'b0);
  endtask

  task automatic test_reset_mid();
    m_ARVALID = 1; m_ARADDR = 32'h0000_1000; m_ARID = 8'h66; m_ARLEN = 8'd3;
    step();
    m_ARVALID = 0; s1_ARREADY = 1;
    step();
    s1_ARREADY = 0; rd_RVALID = 1; m_RREADY = 1;
    step();
    rd_RVALID = 0; m_RREADY = 0;
    total++;
    if (obs() !== expv(0, 0, 1, 0)) begin
      bad++; $display("FAIL reset_mid_pre: got %b want %b", obs(), expv(0, 0, 1, 0));
    end
    #2 ARESET = 1;
    #1;
    total++;
    if (obs() !== expv(1, 0, 0, 0) || s_ARADDR !== 32'd0 || s_ARID !== 8'd0) begin
      bad++; $display("FAIL reset_mid: got %b addr %h want %b addr 0", obs(), s_ARADDR, expv(1, 0, 0, 0));
    end
    step();
    ARESET = 0;
    step();
    // The abandoned burst must not leak beat count into a fresh one.
    run_txn("after_reset", 32'h0000_0010, 8'h67, 8'd1, 0, 1, 1'b0);
  endtask

  task automatic test_unmapped();
`ifdef RD_DECERR_EN
    m_ARVALID = 1; m_ARADDR = 32'h0002_0000; m_ARID = 8'h5A; m_ARLEN = 8'd2;
    step();
    m_ARVALID = 0;
    for (int i = 0; i <= 2; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        m_RREADY = 0;
        step();
      end
      total++;
      if (obs() !== expv(0, 0, 0, 0) ||
          {err_RVALID, err_RID, err_RDATA, err_RRESP, err_RLAST} !== {1'b1, 8'h5A, 32'd0, 2'b11, i == 2}) begin
        bad++; $display("FAIL decerr_beat%0d: got %b v%b id%h d%h r%b l%b", i, obs(),
                        err_RVALID, err_RID, err_RDATA, err_RRESP, err_RLAST);
      end
      m_RREADY = 1;
      step();
    end
    m_RREADY = 0;
    total++;
    if (obs() !== expv(1, 0, 0, 0) || err_RVALID !== 1'b0) begin
      bad++; $display("FAIL decerr_done: got %b err_RVALID %b want %b 0", obs(), err_RVALID, expv(1, 0, 0, 0));
    end
`else
    run_txn("unmapped_default", 32'h0002_0000, 8'h5A, 8'd2, 1, 2, 1'b0);
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [7:0]  len;
      int last_at;
      case ($urandom_range(0, 2))
        0: a = S1_BASE + 32'($urandom_range(0, 32'hFFFF));
        1: a = S2_BASE + 32'($urandom_range(0, 32'hFFFF));
`ifdef RD_DECERR_EN
        default: a = S2_BASE + 32'($urandom_range(0, 32'hFFFF));
`else
        default: a = 32'h0002_0000 + 32'($urandom_range(0, 32'h00FF_FFFF));
`endif
      endcase
      len = 8'($urandom_range(0, 7));
      last_at = ($urandom_range(0, 3) != 0) ? int'(len) : $urandom_range(0, int'(len) + 2);
      run_txn("random", a, 8'($urandom), len, $urandom_range(0, 3), last_at, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_s1_burst();
    test_s2_wait();
    test_back_to_back();
    test_len_err();
    test_reset_mid();
    test_unmapped();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
